wb_arbiter: RTL

Writeback arbiter for the RV64 core; it sits directly upstream of the 64-bit register file and produces its write port (address, data, write enable). It merges two result sources into one register-file write per cycle: the in-order pipeline, which has priority and can never be back-pressured, and a long-latency unit (mul/div) that uses a valid/ready handshake. It also formats load data by width and sign, and keeps a busy scoreboard that stalls decode on hazards with outstanding long-latency results.

---
 rtl/wb_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter - writeback arbiter in front of the 64-bit register file.
//
// Merges the in-order pipeline result (highest priority, never stalled) and
// a long-latency unit result (valid/ready) into one registered write port.
// The pipeline result is formatted by load width/sign when p_is_load is set.
// A busy scoreboard tracks outstanding long-latency destinations and raises
// stall on decode hazards. A starvation counter raises hold so upstream
// drops p_valid for one cycle and lets the long unit through.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   p_valid/p_rd/p_data             pipeline result (always accepted)
//   p_is_load/p_funct3              load formatting control
//   l_valid/l_ready/l_rd/l_data     long-unit result handshake
//   iss_valid/iss_rd                long-latency op issue (sets busy)
//   dec_rs1/dec_rs2/dec_rd          decode register numbers for hazard check
//   stall, hold                     combinational control outputs
//   we/a3/wd                        registered register-file write port
//   busy                            scoreboard, bit 0 always 0
module wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_valid,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_data,
  input  logic            p_is_load,
  input  logic [2:0]      p_funct3,
  input  logic            l_valid,
  output logic            l_ready,
  input  logic [4:0]      l_rd,
  input  logic [XLEN-1:0] l_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall,
  output logic            hold,
  output logic            we,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd,
  output logic [31:0]     busy
);

  localparam int CW = 4;

  // Load formatting: extend the right-aligned load data by width and sign.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                               input logic            is_load,
                                               input logic [2:0]      f3);
    logic [XLEN-1:0] r;
    r = d;
    if (is_load) begin
      case (f3)
        3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
        3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
        3'b010:  r = {{(XLEN-32){d[31]}}, d[31:0]};
        3'b011:  r = d;
        3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
        3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
        3'b110:  r = {{(XLEN-32){1'b0}}, d[31:0]};
        3'b111:  r = d;
        default: r = d;
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic            pw_s;
  logic            lh_s;
  logic            l_ready_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     busy_nxt_s;
  logic [CW-1:0]   starve_nxt_s;
  logic            we_r;
  logic [4:0]      a3_r;
  logic [XLEN-1:0] wd_r;
  logic [31:0]     busy_r;
  logic [CW-1:0]   starve_r;

  // rst_n gates l_ready so an in-flight long result is never taken in reset.
  assign pw_s      = p_valid & (p_rd != 5'd0);
  assign l_ready_s = rst_n & ~pw_s;
  assign lh_s      = l_valid & l_ready_s;

  // Scoreboard masks; set is applied after clear so a same-cycle set wins.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (iss_valid && (iss_rd != 5'd0)) begin
      set_mask_s[iss_rd] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (lh_s) begin
      clr_mask_s[l_rd] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Starvation counter next state: count refused cycles, clear otherwise.
  always_comb begin
    starve_nxt_s = starve_r;
    if (!l_valid || lh_s) begin
      starve_nxt_s = {CW{1'b0}};
    end else if (starve_r != CW'(STARVE_MAX)) begin
      starve_nxt_s = starve_r + CW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Write-port register: pipeline first, then long unit; a3/wd hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r <= 1'b0;
      a3_r <= 5'd0;
      wd_r <= {XLEN{1'b0}};
    end else if (pw_s) begin
      we_r <= 1'b1;
      a3_r <= p_rd;
      wd_r <= fmt_load(p_data, p_is_load, p_funct3);
    end else if (lh_s && (l_rd != 5'd0)) begin
      we_r <= 1'b1;
      a3_r <= l_rd;
      wd_r <= l_data;
    end else begin
      we_r <= 1'b0;
    end
  end

  // Scoreboard and starvation counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 32'd0;
      starve_r <= {CW{1'b0}};
    end else begin
      busy_r   <= busy_nxt_s;
      starve_r <= starve_nxt_s;
    end
  end

  assign l_ready = l_ready_s;
  assign stall   = busy_r[dec_rs1] | busy_r[dec_rs2] | busy_r[dec_rd];
  assign hold    = (starve_r == CW'(STARVE_MAX));
  assign we      = we_r;
  assign a3      = a3_r;
  assign wd      = wd_r;
  assign busy    = busy_r;

endmodule
